// File: rtl/instr_encoder.sv
// Packs a symbolic instruction request into a MIPS word and writes it to imem at an auto-incrementing PC.
// Latency: accept -> CHECK -> WRITE (imem_we one cycle), one word per 3 cycles at best.
// Backpressure: ready is low outside IDLE and while org_load is asserted.
module instr_encoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        org_load,
  input  logic [31:0] org_addr,
  input  logic        valid,
  output logic        ready,
  input  logic [4:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  input  logic [31:0] target,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [4:0]  kind_q, rd_q, rs_q, rt_q;
  logic [15:0] imm_q;
  logic [31:0] target_q;

  logic        accept;
  logic [31:0] pc4;
  logic [31:0] diff;
  logic        misalign;
  logic        br_fits;
  logic [5:0]  op, funct;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic        is_r, is_j, is_br, bad_kind;
  logic [31:0] word;
  logic        enc_err;

  assign ready   = (state == S_IDLE) && !org_load;
  assign accept  = valid && ready;
  assign imem_we = (state == S_WRITE);

  // Branch offset is diff >>> 2; it fits in 16 bits when diff[31:17] are all sign copies.
  assign pc4      = pc + 32'd4;
  assign diff     = target_q - pc4;
  assign misalign = |diff[1:0];
  assign br_fits  = (diff[31:17] == {15{diff[31]}});

  always_comb begin
    op       = 6'b000000;
    funct    = 6'b000000;
    f_rs     = rs_q;
    f_rt     = rt_q;
    f_rd     = rd_q;
    is_r     = 1'b0;
    is_j     = 1'b0;
    is_br    = 1'b0;
    bad_kind = 1'b0;
    case (kind_q)
      5'd0:  begin is_r = 1'b1; funct = 6'b100001; end
      5'd1:  begin is_r = 1'b1; funct = 6'b100011; end
      5'd2:  begin is_r = 1'b1; funct = 6'b100100; end
      5'd3:  begin is_r = 1'b1; funct = 6'b100101; end
      5'd4:  begin is_r = 1'b1; funct = 6'b101011; end
      5'd5:  begin is_r = 1'b1; funct = 6'b011001; f_rd = 5'd0; end
      5'd6:  begin is_r = 1'b1; funct = 6'b010000; f_rs = 5'd0; f_rt = 5'd0; end
      5'd7:  begin is_r = 1'b1; funct = 6'b010010; f_rs = 5'd0; f_rt = 5'd0; end
      5'd8:  op = 6'b100011;
      5'd9:  op = 6'b101011;
      5'd10: begin op = 6'b000100; is_br = 1'b1; end
      5'd11: op = 6'b001001;
      5'd12: op = 6'b001101;
      5'd13: begin op = 6'b000010; is_j = 1'b1; end
      5'd14: begin op = 6'b001111; f_rs = 5'd0; end
      5'd15: begin op = 6'b000001; f_rt = 5'd0; is_br = 1'b1; end
      5'd16: begin op = 6'b000011; is_j = 1'b1; end
      default: bad_kind = 1'b1;
    endcase
  end

  always_comb begin
    word = {op, f_rs, f_rt, imm_q};
    if (is_j)
      word = {op, target_q[27:2]};
    else if (is_r)
      word = {op, f_rs, f_rt, f_rd, 5'b00000, funct};
    else if (is_br)
      word = {op, f_rs, f_rt, diff[17:2]};
    enc_err = bad_kind
            | (is_br & (misalign | !br_fits))
            | (is_j  & (misalign | (target_q[31:28] != pc4[31:28])));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CHECK;
      S_CHECK: state_nxt = enc_err ? S_IDLE : S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q   <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      target_q <= '0;
    end else if (accept) begin
      kind_q   <= kind;
      rd_q     <= rd;
      rs_q     <= rs;
      rt_q     <= rt;
      imm_q    <= imm;
      target_q <= target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      count      <= '0;
      err        <= 1'b0;
      imem_addr  <= RESET_PC;
      imem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (org_load) begin
          pc    <= org_addr & ~32'h3;
          count <= '0;
          err   <= 1'b0;
        end
        S_CHECK: if (enc_err) begin
          err <= 1'b1;
        end else begin
          imem_addr  <= pc;
          imem_wdata <= word;
        end
        S_WRITE: begin
          pc    <= pc4;
          count <= count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
